adc1align: RTL and testbench

ADC1ALIGN -- requirements
Module: adc1align

---
 rtl/adc1align.sv | 194 +++++++++++++++++++
 tb/tb_adc1align.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc1align.sv
// adc1align: word-alignment controller for a one-line ADC receiver.
// Resets the ISERDES, calibrates the IODELAY, then searches all
// bitslip positions at every IODELAY tap for a window of NMATCH
// consecutive training words.
module adc1align #(
    parameter logic [5:0] PATTERN = 6'b111000,
    parameter int         NMATCH  = 16,
    parameter int         SETTLE  = 8,
    parameter int         MAXTAP  = 255
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic [5:0] DIN,
    input  logic       BUSY,
    output logic       SRST,
    output logic       DCAL,
    output logic       DRST,
    output logic       DINC,
    output logic       BS,
    output logic [7:0] TAP,
    output logic [2:0] SLIPS,
    output logic       DONE,
    output logic       FAIL
);

    typedef enum logic [3:0] {
        S_IDLE, S_SRES, S_CAL, S_CALW, S_DRES, S_WAIT,
        S_CHECK, S_SLIP, S_INCD, S_LOCK, S_FAILED
    } state_t;

    // One shared cycle counter serves SRES, CALW (needs 0..257) and WAIT.
    localparam int CNT_W  = (SETTLE > 512) ? $clog2(SETTLE) : 9;
    localparam int MCNT_W = (NMATCH > 1) ? $clog2(NMATCH) : 1;

    localparam logic [CNT_W-1:0]  SRES_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CALW_IGNORE = CNT_W'(2);
    localparam logic [CNT_W-1:0]  CALW_LAST   = CNT_W'(257);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [MCNT_W-1:0] MATCH_LAST  = MCNT_W'(NMATCH - 1);
    localparam logic [7:0]        TAP_MAX     = 8'(MAXTAP);
    localparam logic [2:0]        SLIP_MAX    = 3'd5;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MCNT_W-1:0]  mcnt_q, mcnt_d;
    logic [7:0]         tap_q, tap_d;
    logic [2:0]         slips_q, slips_d;
    logic               srst_q, srst_d;
    logic               dcal_q, dcal_d;
    logic               drst_q, drst_d;
    logic               dinc_q, dinc_d;
    logic               bs_q, bs_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    // State register and registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: every flop here uses <= so all registers update from the
        // same pre-edge values; blocking = would create ordering races.
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            tap_q   <= '0;
            slips_q <= '0;
            srst_q  <= 1'b1;
            dcal_q  <= 1'b0;
            drst_q  <= 1'b0;
            dinc_q  <= 1'b0;
            bs_q    <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            tap_q   <= tap_d;
            slips_q <= slips_d;
            srst_q  <= srst_d;
            dcal_q  <= dcal_d;
            drst_q  <= drst_d;
            dinc_q  <= dinc_d;
            bs_q    <= bs_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state, counters and tap/slip bookkeeping.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        tap_d   = tap_q;
        slips_d = slips_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SRES;
                    cnt_d   = '0;
                end
            end
            S_SRES: begin
                if (cnt_q == SRES_LAST) state_d = S_CAL;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CAL: begin
                state_d = S_CALW;
                cnt_d   = '0;
            end
            S_CALW: begin
                // BUSY is not yet valid for the first two cycles after DCAL.
                if (cnt_q >= CALW_IGNORE && !BUSY) begin
                    state_d = S_DRES;
                    tap_d   = '0;
                    slips_d = '0;
                end else if (cnt_q == CALW_LAST) begin
                    state_d = S_FAILED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRES: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    mcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (DIN == PATTERN) begin
                    if (mcnt_q == MATCH_LAST) state_d = S_LOCK;
                    else                      mcnt_d  = mcnt_q + MCNT_W'(1);
                end else if (slips_q < SLIP_MAX) begin
                    state_d = S_SLIP;
                    slips_d = slips_q + 3'd1;
                end else begin
                    // The tap step is decided here so DINC and TAP move together.
                    state_d = S_INCD;
                    if (tap_q != TAP_MAX) begin
                        tap_d   = tap_q + 8'd1;
                        slips_d = '0;
                    end
                end
            end
            S_SLIP: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_INCD: begin
                // No DINC pulse means the last tap was already exhausted.
                state_d = dinc_q ? S_WAIT : S_FAILED;
                cnt_d   = '0;
            end
            S_LOCK, S_FAILED: begin
                if (START) begin
                    state_d = S_SRES;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so each output is a flop aligned with its state.
    always_comb begin
        srst_d = (state_d == S_IDLE) || (state_d == S_SRES);
        dcal_d = (state_d == S_CAL);
        drst_d = (state_d == S_DRES);
        bs_d   = (state_d == S_SLIP);
        dinc_d = (state_d == S_INCD) && (tap_q != TAP_MAX);
        done_d = (state_d == S_LOCK);
        fail_d = (state_d == S_FAILED);
    end

    assign SRST  = srst_q;
    assign DCAL  = dcal_q;
    assign DRST  = drst_q;
    assign DINC  = dinc_q;
    assign BS    = bs_q;
    assign TAP   = tap_q;
    assign SLIPS = slips_q;
    assign DONE  = done_q;
    assign FAIL  = fail_q;

endmodule

// File: tb/tb_adc1align.sv
// tb_adc1align: scoreboard bench for adc1align. A receiver model turns
// the DUT's DRST/DINC/BS pulses into a tap/slip position and drives DIN;
// a search model predicts the pulse/result sequence of each run.
module tb_adc1align;

    localparam logic [5:0] PAT     = 6'b111000;
    localparam int         NM      = 16;
    localparam int         ST      = 8;
    localparam int         MT      = 3;
    localparam int         RST_VEC = 32'h20000;

    typedef enum int {M_CONST, M_ROT2, M_TAP3, M_NEVER, M_GLITCH, M_RAND} mode_t;
    typedef enum int {EV_DCAL, EV_DRST, EV_DINC, EV_BS, EV_DONE, EV_FAIL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       tap;
        int       slips;
    } ev_t;

    logic       clk;
    logic       RSTN, START, BUSY;
    logic [5:0] DIN;
    logic       SRST, DCAL, DRST, DINC, BS, DONE, FAIL;
    logic [7:0] TAP;
    logic [2:0] SLIPS;

    int    checks = 0;
    int    failures = 0;
    ev_t   exp_q[$];
    mode_t mode = M_CONST;
    int    rt = 0, rps = 0;
    int    busy_len = 0, bcnt = 0;
    int    mtap = 0, mpslip = 0, kcnt = 0;
    int    cyc = 0, dcal_cyc = 0;
    int    last_tap = 0, last_slips = 0;
    bit    abort = 1'b1, stuck_mode = 1'b0;
    logic  dcal_p = 0, drst_p = 0, dinc_p = 0, bs_p = 0, done_p = 0, fail_p = 0;

    adc1align #(.PATTERN(PAT), .NMATCH(NM), .SETTLE(ST), .MAXTAP(MT)) dut (
        .CLK(clk), .RSTN(RSTN), .START(START), .DIN(DIN), .BUSY(BUSY),
        .SRST(SRST), .DCAL(DCAL), .DRST(DRST), .DINC(DINC), .BS(BS),
        .TAP(TAP), .SLIPS(SLIPS), .DONE(DONE), .FAIL(FAIL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    function automatic ev_t mk(input ev_kind_t k, input int t, input int s);
        ev_t e;
        e.kind = k; e.tap = t; e.slips = s;
        return e;
    endfunction

    function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
        logic [11:0] sh;
        sh = {w, w} >> (6 - n);
        return sh[5:0];
    endfunction

    // Does the receiver deliver the training word at this tap and physical slip?
    function automatic bit win_match(input int t, input int ps);
        case (mode)
            M_CONST:  return 1'b1;
            M_ROT2:   return ps == 2;
            M_TAP3:   return t == 3;
            M_GLITCH: return t == 0;
            M_RAND:   return (t == rt) && (ps == rps);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] drive_word();
        logic [5:0] w;
        if (mode == M_GLITCH && kcnt == ST + 16) return ~PAT;
        if (win_match(mtap, mpslip)) return PAT;
        if (mode == M_ROT2) return rotl(PAT, (8 - mpslip) % 6);
        w = 6'($urandom);
        while (w == PAT) w = 6'($urandom);
        return w;
    endfunction

    function automatic int out_vec();
        return int'({SRST, DCAL, DRST, DINC, BS, DONE, FAIL, TAP, SLIPS});
    endfunction

    // Predict a run: calibrate, reset delay, then walk taps and slip positions.
    task automatic plan(input bit stuck, input bit spoil);
        int  ps;
        bit  first;
        exp_q.push_back(mk(EV_DCAL, 0, 0));
        if (stuck) begin
            exp_q.push_back(mk(EV_FAIL, last_tap, last_slips));
            return;
        end
        exp_q.push_back(mk(EV_DRST, 0, 0));
        ps = 0;
        first = 1'b1;
        for (int t = 0; t <= MT; t++) begin
            for (int s = 0; s < 6; s++) begin
                if (win_match(t, ps) && !(spoil && first)) begin
                    exp_q.push_back(mk(EV_DONE, t, s));
                    last_tap = t;
                    last_slips = s;
                    return;
                end
                first = 1'b0;
                if (s < 5) begin
                    exp_q.push_back(mk(EV_BS, 0, 0));
                    ps = (ps + 1) % 6;
                end
            end
            if (t < MT) exp_q.push_back(mk(EV_DINC, 0, 0));
        end
        exp_q.push_back(mk(EV_FAIL, MT, 5));
        last_tap = MT;
        last_slips = 5;
    endtask

    task automatic observe(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got %s with nothing outstanding (TAP=%0d SLIPS=%0d)",
                     kind.name(), TAP, SLIPS);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("event_kind(exp %s)", e.kind.name()), int'(kind), int'(e.kind));
        if (kind == EV_DONE || kind == EV_FAIL) begin
            check("final_tap", int'(TAP), e.tap);
            check("final_slips", int'(SLIPS), e.slips);
            if (kind == EV_FAIL && stuck_mode) check("calw_timeout_cycles", cyc - dcal_cyc, 259);
        end
    endtask

    // Monitor plus receiver/IODELAY model, sampling on the falling edge.
    initial begin : monitor
        int  npulse;
        bit  wide;
        DIN  = 6'd0;
        BUSY = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (SRST) mpslip = 0;
            if (DRST) begin
                mtap = 0;
                kcnt = 0;
            end else begin
                kcnt++;
            end
            if (DINC) mtap++;
            if (BS) mpslip = (mpslip + 1) % 6;
            if (DCAL) bcnt = busy_len;
            else if (bcnt > 0) bcnt--;
            BUSY = (bcnt > 0);
            DIN  = drive_word();
            if (!abort) begin
                npulse = int'(DCAL) + int'(DRST) + int'(DINC) + int'(BS);
                wide = (DCAL && dcal_p) || (DRST && drst_p) || (DINC && dinc_p) || (BS && bs_p);
                if (npulse > 0) check("pulse_shape", int'({npulse > 1, wide}), 0);
                if (DCAL) begin
                    dcal_cyc = cyc;
                    observe(EV_DCAL);
                end
                if (DRST) observe(EV_DRST);
                if (DINC) observe(EV_DINC);
                if (BS) observe(EV_BS);
                if (DONE && !done_p) observe(EV_DONE);
                if (FAIL && !fail_p) observe(EV_FAIL);
            end
            dcal_p = DCAL; drst_p = DRST; dinc_p = DINC; bs_p = BS;
            done_p = DONE; fail_p = FAIL;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input mode_t m, input int bl, input bit stuck, input bit spoil,
                       input bit poke, input string name);
        int n;
        mode = m;
        busy_len = bl;
        stuck_mode = stuck;
        plan(stuck, spoil);
        START = 1'b1;
        tick();
        START = 1'b0;
        check({name, "_start"}, int'({DONE, FAIL, SRST}), 1);
        if (poke) begin
            n = 0;
            while (!DRST && n < 500) begin
                tick();
                n++;
            end
            repeat (3) tick();
            START = 1'b1;
            tick();
            START = 1'b0;
        end
        n = 0;
        while (!(DONE || FAIL) && n < 4000) begin
            tick();
            n++;
        end
        if (!(DONE || FAIL)) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no DONE/lock-fail level within %0d cycles", name, n);
        end
        repeat (3) tick();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic abort_with_reset(input bit start_too, input string name);
        abort = 1'b1;
        RSTN  = 1'b0;
        START = start_too;
        tick();
        check(name, out_vec(), RST_VEC);
        RSTN  = 1'b1;
        START = 1'b0;
        exp_q.delete();
        last_tap = 0;
        last_slips = 0;
        tick();
        abort = 1'b0;
    endtask

    initial begin : stim
        int n;
        RSTN  = 1'b0;
        START = 1'b0;
        repeat (3) tick();
        check("reset_state", out_vec(), RST_VEC);
        RSTN = 1'b1;
        tick();
        abort = 1'b0;

        run(M_CONST,  3,   1'b0, 1'b0, 1'b0, "const");
        run(M_ROT2,   3,   1'b0, 1'b0, 1'b0, "rot2");
        run(M_TAP3,   5,   1'b0, 1'b0, 1'b1, "tap3_start_in_wait");
        run(M_NEVER,  2,   1'b0, 1'b0, 1'b0, "never");
        run(M_GLITCH, 0,   1'b0, 1'b1, 1'b0, "glitch15");
        run(M_CONST,  300, 1'b1, 1'b0, 1'b0, "busy_stuck");
        for (int i = 0; i < 4; i++) begin
            rt  = int'($urandom_range(0, MT));
            rps = int'($urandom_range(0, 5));
            run(M_RAND, int'($urandom_range(0, 20)), 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        // Abort a search in the middle of a bitslip pulse.
        mode = M_NEVER;
        busy_len = 2;
        stuck_mode = 1'b0;
        plan(1'b0, 1'b0);
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!BS && n < 1000) begin
            tick();
            n++;
        end
        if (!BS) begin
            checks++;
            failures++;
            $display("FAIL slip_wait_timeout: no BS within %0d cycles", n);
        end
        abort_with_reset(1'b0, "reset_in_slip");

        // Lock again, then reset from LOCK with START held during reset.
        run(M_CONST, 1, 1'b0, 1'b0, 1'b0, "relock");
        abort_with_reset(1'b1, "reset_in_lock");
        repeat (6) tick();
        check("start_ignored_in_reset", int'(SRST), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
